// File: rtl/led_matrix_pwm_scan_pkg.sv
// Shared constants and helpers for the multiplexed LED matrix PWM scanner.
// Holds the default geometry/timing values and clog2_safe, which sizes
// counters so that even a one-value range gets a 1-bit register.
package led_matrix_pkg;

    localparam int ROWS_DEF     = 4;
    localparam int COLS_DEF     = 4;
    localparam int PWM_BITS_DEF = 4;
    localparam int DIV_DEF      = 32;
    localparam int BLANK_DEF    = 2;

    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_matrix_pwm_scan_if.sv
// Bus between the level source and the LED matrix scanner.
//   en          : scan enable (master -> scanner)
//   level       : packed per-LED brightness, LED i at [i*PWM_BITS +: PWM_BITS]
//   aled        : column select, active low (scanner -> pins)
//   kled_tri    : row output enable, active high (scanner -> pins)
//   frame_start : one-cycle pulse at the start of each frame
interface led_matrix_pwm_scan_if
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF
) ();

    logic                          en;
    logic [ROWS*COLS*PWM_BITS-1:0] level;
    logic [COLS-1:0]               aled;
    logic [ROWS-1:0]               kled_tri;
    logic                          frame_start;

    modport master (output en, level, input aled, kled_tri, frame_start);
    modport slave  (input en, level, output aled, kled_tri, frame_start);

endinterface

// File: rtl/led_matrix_pwm_scan_timer.sv
// Scan timing for the LED matrix: cycle-in-slot, slot (LED index) and PWM
// phase counters. Everything clears synchronously while en_i is low.
//   clk, rst_n   : clock, async active-low reset
//   en_i         : scan enable
//   slot_o       : current LED index
//   phase_o      : current PWM phase, 0 .. 2^PWM_BITS-2
//   blank_o      : current cycle lies in the blanking window of the slot
//   frame_tick_o : enabled and at slot 0, cycle 0 (frame boundary)
module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int N        = 16,
    parameter int DIV      = DIV_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int BLANK    = BLANK_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    output logic [clog2_safe(N)-1:0]  slot_o,
    output logic [PWM_BITS-1:0]       phase_o,
    output logic                      blank_o,
    output logic                      frame_tick_o
);

    localparam int CYC_W  = clog2_safe(DIV);
    localparam int SLOT_W = clog2_safe(N);
    localparam logic [CYC_W-1:0]    CYC_LAST  = CYC_W'(DIV - 1);
    localparam logic [CYC_W-1:0]    BLANK_C   = CYC_W'(BLANK);
    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(N - 1);
    localparam logic [PWM_BITS-1:0] PH_LAST   = PWM_BITS'(2**PWM_BITS - 2);

    logic [CYC_W-1:0]    cyc_q,   cyc_d;
    logic [SLOT_W-1:0]   slot_q,  slot_d;
    logic [PWM_BITS-1:0] phase_q, phase_d;

    always_comb begin
        cyc_d   = cyc_q + 1'b1;
        slot_d  = slot_q;
        phase_d = phase_q;
        if (!en_i) begin
            cyc_d   = '0;
            slot_d  = '0;
            phase_d = '0;
        end else if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (slot_q == SLOT_LAST) begin
                slot_d  = '0;
                // Phase only spans 2^PWM_BITS-1 values so full level is always lit.
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            slot_q  <= '0;
            phase_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            slot_q  <= slot_d;
            phase_q <= phase_d;
        end
    end

    assign slot_o       = slot_q;
    assign phase_o      = phase_q;
    assign blank_o      = (cyc_q < BLANK_C);
    assign frame_tick_o = en_i && (slot_q == '0) && (cyc_q == '0);

endmodule

// File: rtl/led_matrix_pwm_scan.sv
// Multiplexed ROWS x COLS LED matrix driver with per-LED PWM brightness.
// Lights one LED per slot, blanks the start of every slot against ghosting
// and snapshots all levels at the frame boundary against tearing.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of led_matrix_pwm_scan_if (en, level in;
//                aled, kled_tri, frame_start out, all registered)
module led_matrix_pwm_scan
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int BLANK    = BLANK_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_matrix_pwm_scan_if.slave  bus
);

    localparam int N      = ROWS * COLS;
    localparam int SLOT_W = clog2_safe(N);
    localparam int LVL_W  = N * PWM_BITS;

    if (ROWS < 1)                         begin : g_bad_rows  $error("ROWS must be >= 1");            end
    if (COLS < 1)                         begin : g_bad_cols  $error("COLS must be >= 1");            end
    if (PWM_BITS < 1)                     begin : g_bad_pwm   $error("PWM_BITS must be >= 1");        end
    if (DIV < 2)                          begin : g_bad_div   $error("DIV must be >= 2");             end
    if ((BLANK < 1) || (BLANK > DIV - 1)) begin : g_bad_blank $error("BLANK must be in 1..DIV-1");    end

    logic [SLOT_W-1:0]   slot;
    logic [PWM_BITS-1:0] phase;
    logic                blank;
    logic                frame_tick;

    led_scan_timer #(
        .N        (N),
        .DIV      (DIV),
        .PWM_BITS (PWM_BITS),
        .BLANK    (BLANK)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (bus.en),
        .slot_o       (slot),
        .phase_o      (phase),
        .blank_o      (blank),
        .frame_tick_o (frame_tick)
    );

    logic [LVL_W-1:0] snap_q, snap_d;
    logic [COLS-1:0]  aled_q, aled_d;
    logic [ROWS-1:0]  kled_q, kled_d;
    logic             fs_q, fs_d;
    logic             lit;
    logic [ROWS-1:0]  row_oh;
    logic [COLS-1:0]  col_oh;

    // Snapshot loads on the same edge that issues frame_start; slot 0 is
    // still blanked then, so no LED is ever judged on a stale level.
    assign snap_d = frame_tick ? bus.level : snap_q;

    // Decode the current slot into row/column one-hots and its lit state.
    always_comb begin
        lit    = 1'b0;
        row_oh = '0;
        col_oh = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(slot) == i) begin
                lit              = (snap_q[i*PWM_BITS +: PWM_BITS] > phase);
                row_oh[i / COLS] = 1'b1;
                col_oh[i % COLS] = 1'b1;
            end
        end
    end

    always_comb begin
        aled_d = '1;
        kled_d = '0;
        fs_d   = frame_tick;
        if (bus.en && !blank) begin
            aled_d = ~col_oh;
            kled_d = lit ? row_oh : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            aled_q <= '1;
            kled_q <= '0;
            fs_q   <= 1'b0;
        end else begin
            snap_q <= snap_d;
            aled_q <= aled_d;
            kled_q <= kled_d;
            fs_q   <= fs_d;
        end
    end

    assign bus.aled        = aled_q;
    assign bus.kled_tri    = kled_q;
    assign bus.frame_start = fs_q;

endmodule
